bp_me_cce_mem_arbiter: RTL and testbench
========================================

BP_ME_CCE_MEM_ARBITER -- requirements
Module: bp_me_cce_mem_arbiter

Interface
REQ-001 Parameter num_req_p, default 2: number of CCE requesters sharing one memory port (2..8).
REQ-002 Parameter cmd_width_p, default 64: width of one mem_cmd packet.
REQ-003 Parameter data_cmd_width_p, default 576: width of one mem_data_cmd packet.
REQ-004 Parameter resp_width_p, default 64: width of one mem_resp packet.
REQ-005 Parameter data_resp_width_p, default 576: width of one mem_data_resp packet.
REQ-006 Parameter outstanding_p, default 4: tag FIFO depth per response class.
REQ-007 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-008 Port clk_i, input, 1: sole clock, rising edge.
REQ-009 Port reset_n_i, input, 1: asynchronous active-low reset.
REQ-010 Ports cce_mem_cmd_i / _v_i / _yumi_o, in/in/out, num_req_p*cmd_width_p / num_req_p / num_req_p: per-CCE read commands.
REQ-011 Ports cce_mem_data_cmd_i / _v_i / _yumi_o, in/in/out, num_req_p*data_cmd_width_p / num_req_p / num_req_p: per-CCE write commands.
REQ-012 Ports cce_mem_resp_o / _v_o / _ready_i, out/out/in, resp_width_p / num_req_p / num_req_p: write acks; payload broadcast, valid one-hot.
REQ-013 Ports cce_mem_data_resp_o / _v_o / _ready_i, out/out/in, data_resp_width_p / num_req_p / num_req_p: read data, broadcast payload, one-hot valid.
REQ-014 Ports mem_cmd_o / _v_o / _yumi_i and mem_data_cmd_o / _v_o / _yumi_i: single memory-side command channels.
REQ-015 Ports mem_resp_i / _v_i / _ready_o and mem_data_resp_i / _v_i / _ready_o: single memory-side response channels.
REQ-016 Port error_o, output, 1: sticky flag, response received with empty tag FIFO.

Function
REQ-017 FSM states e_idle, e_cmd, e_data_cmd; a single grant owns the memory command side.
REQ-018 e_idle: round-robin search from rr_ptr over requesters with cmd_v or data_cmd_v; data_cmd_v wins over cmd_v within one requester.
REQ-019 e_idle -> e_cmd only if read tag FIFO not full; -> e_data_cmd only if write tag FIFO not full; otherwise that candidate is skipped that cycle.
REQ-020 In e_cmd: mem_cmd_v_o = granted cce_mem_cmd_v_i, payload muxed; cce_mem_cmd_yumi_o[g] = mem_cmd_yumi_i; e_data_cmd symmetric.
REQ-021 On memory yumi: push grant id to matching tag FIFO, rr_ptr <= g+1 modulo num_req_p (wrap to 0), return to e_idle.
REQ-022 Grant latency: one cycle from request to mem_*_v_o; max one command accepted per two cycles.
REQ-023 Requester dropping valid while granted is illegal; arbiter holds grant (no timeout).
REQ-024 mem_data_resp_ready_o = read FIFO nonempty & cce_mem_data_resp_ready_i[head]; cce_mem_data_resp_v_o = onehot(head) & mem_data_resp_v_i & nonempty; pop on handshake. mem_resp path symmetric with write FIFO.
REQ-025 Memory returns responses in command order per class; arbiter relies on this.
REQ-026 Response with empty FIFO: ready_o low, no valid to any CCE, error_o set.
REQ-027 Full FIFO blocks new grant even if a pop occurs in the same cycle; simultaneous push and pop on non-full FIFO keeps count.
REQ-028 Response paths operate concurrently with command FSM.

Reset
REQ-029 reset_n_i low: state e_idle, rr_ptr 0, both FIFOs empty, error_o 0, all valid/yumi/ready outputs 0 asynchronously.
REQ-030 Reset mid-grant or with outstanding tags discards them; no response routed afterward for pre-reset commands.

Structure
REQ-031 FSM state enum and requester-id width macro live in bp_me package (bp_cce_pkg).
REQ-032 Tag FIFO is sub-module bp_me_arb_tag_fifo (depth outstanding_p, width clog2(num_req_p)), instantiated twice.

Verification
REQ-033 Reset, CCE0 and CCE1 read simultaneously -> CCE0 granted first, CCE1 next; data responses routed 0 then 1.
REQ-034 CCE1 issues write and read same cycle -> mem_data_cmd first, then mem_cmd; ack to CCE1 only.
REQ-035 Five reads from CCE0, no responses, outstanding_p=4 -> fifth held, cmd_yumi low until one response popped.
REQ-036 mem_resp_v_i with empty write FIFO -> mem_resp_ready_o 0, error_o 1 and stays set.
REQ-037 reset_n_i pulsed low while e_cmd with 2 tags outstanding -> all outputs 0 same cycle, FIFOs empty after release.

Source files
------------

// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE-to-memory arbiter: command FSM states and requester-id sizing.
package bp_cce_pkg;

   typedef enum logic [1:0] {
      e_idle     = 2'd0,
      e_cmd      = 2'd1,
      e_data_cmd = 2'd2
   } bp_me_arb_state_e;

   // Requester-id width; a single requester still needs one bit for the tag.
   function automatic int bp_me_req_id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/bp_me_arb_tag_fifo.sv
// Small tag FIFO remembering which requester owns each outstanding memory command.
module bp_me_arb_tag_fifo #(
   parameter int depth_p = 4,
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic               empty_o,
   output logic               full_o
);

   localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
   localparam int cnt_w = $clog2(depth_p + 1);

   logic [width_p-1:0] mem_q [depth_p];
   logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
   logic [cnt_w-1:0]   count_q, count_d;
   logic               push_ok, pop_ok;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(depth_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == cnt_w'(depth_p));
   assign data_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/bp_me_cce_mem_arbiter.sv
// Shares one memory command/response port among num_req_p CCEs; responses are routed
// back by per-class tag FIFOs that rely on in-order memory replies.
//
//   state      | meaning
//   e_idle     | round-robin search for the next requester with a free tag slot
//   e_cmd      | granted read command presented on mem_cmd, waiting for yumi
//   e_data_cmd | granted write command presented on mem_data_cmd, waiting for yumi
module bp_me_cce_mem_arbiter
   import bp_cce_pkg::*;
#(
   parameter int num_req_p         = 2,
   parameter int cmd_width_p       = 64,
   parameter int data_cmd_width_p  = 576,
   parameter int resp_width_p      = 64,
   parameter int data_resp_width_p = 576,
   parameter int outstanding_p     = 4
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,

   input  logic [num_req_p*cmd_width_p-1:0]      cce_mem_cmd_i,
   input  logic [num_req_p-1:0]                  cce_mem_cmd_v_i,
   output logic [num_req_p-1:0]                  cce_mem_cmd_yumi_o,

   input  logic [num_req_p*data_cmd_width_p-1:0] cce_mem_data_cmd_i,
   input  logic [num_req_p-1:0]                  cce_mem_data_cmd_v_i,
   output logic [num_req_p-1:0]                  cce_mem_data_cmd_yumi_o,

   output logic [resp_width_p-1:0]               cce_mem_resp_o,
   output logic [num_req_p-1:0]                  cce_mem_resp_v_o,
   input  logic [num_req_p-1:0]                  cce_mem_resp_ready_i,

   output logic [data_resp_width_p-1:0]          cce_mem_data_resp_o,
   output logic [num_req_p-1:0]                  cce_mem_data_resp_v_o,
   input  logic [num_req_p-1:0]                  cce_mem_data_resp_ready_i,

   output logic [cmd_width_p-1:0]                mem_cmd_o,
   output logic                                  mem_cmd_v_o,
   input  logic                                  mem_cmd_yumi_i,

   output logic [data_cmd_width_p-1:0]           mem_data_cmd_o,
   output logic                                  mem_data_cmd_v_o,
   input  logic                                  mem_data_cmd_yumi_i,

   input  logic [resp_width_p-1:0]               mem_resp_i,
   input  logic                                  mem_resp_v_i,
   output logic                                  mem_resp_ready_o,

   input  logic [data_resp_width_p-1:0]          mem_data_resp_i,
   input  logic                                  mem_data_resp_v_i,
   output logic                                  mem_data_resp_ready_o,

   output logic                                  error_o
);

   localparam int id_w = bp_me_req_id_width(num_req_p);

   bp_me_arb_state_e  state_q, state_d;
   logic [id_w-1:0]   grant_q, grant_d;
   logic [id_w-1:0]   rr_ptr_q, rr_ptr_d;
   logic              error_q, error_d;

   logic              rd_push, rd_pop, rd_empty, rd_full;
   logic              wr_push, wr_pop, wr_empty, wr_full;
   logic [id_w-1:0]   rd_head, wr_head;

   logic [id_w:0]     idx_sum;
   logic [id_w-1:0]   idx;
   logic              found;

   function automatic logic [id_w-1:0] id_inc(input logic [id_w-1:0] g);
      return (g == id_w'(num_req_p - 1)) ? '0 : g + 1'b1;
   endfunction

   function automatic logic [num_req_p-1:0] onehot(input logic [id_w-1:0] g);
      return {{(num_req_p-1){1'b0}}, 1'b1} << g;
   endfunction

   assign mem_cmd_o      = cce_mem_cmd_i[grant_q*cmd_width_p +: cmd_width_p];
   assign mem_data_cmd_o = cce_mem_data_cmd_i[grant_q*data_cmd_width_p +: data_cmd_width_p];

   always_comb begin
      state_d                 = state_q;
      grant_d                 = grant_q;
      rr_ptr_d                = rr_ptr_q;
      mem_cmd_v_o             = 1'b0;
      mem_data_cmd_v_o        = 1'b0;
      cce_mem_cmd_yumi_o      = '0;
      cce_mem_data_cmd_yumi_o = '0;
      rd_push                 = 1'b0;
      wr_push                 = 1'b0;
      idx_sum                 = '0;
      idx                     = '0;
      found                   = 1'b0;
      case (state_q)
         e_idle: begin
            // A candidate whose class FIFO is full is skipped, not demoted to its other class.
            for (int i = 0; i < num_req_p; i++) begin
               idx_sum = {1'b0, rr_ptr_q} + (id_w+1)'(i);
               if (idx_sum >= (id_w+1)'(num_req_p)) idx_sum = idx_sum - (id_w+1)'(num_req_p);
               idx = idx_sum[id_w-1:0];
               if (!found) begin
                  if (cce_mem_data_cmd_v_i[idx]) begin
                     if (!wr_full) begin
                        found   = 1'b1;
                        state_d = e_data_cmd;
                        grant_d = idx;
                     end
                  end else if (cce_mem_cmd_v_i[idx] && !rd_full) begin
                     found   = 1'b1;
                     state_d = e_cmd;
                     grant_d = idx;
                  end
               end
            end
         end
         e_cmd: begin
            mem_cmd_v_o                 = cce_mem_cmd_v_i[grant_q];
            cce_mem_cmd_yumi_o[grant_q] = mem_cmd_yumi_i;
            if (mem_cmd_yumi_i && mem_cmd_v_o) begin
               rd_push  = 1'b1;
               rr_ptr_d = id_inc(grant_q);
               state_d  = e_idle;
            end
         end
         e_data_cmd: begin
            mem_data_cmd_v_o                 = cce_mem_data_cmd_v_i[grant_q];
            cce_mem_data_cmd_yumi_o[grant_q] = mem_data_cmd_yumi_i;
            if (mem_data_cmd_yumi_i && mem_data_cmd_v_o) begin
               wr_push  = 1'b1;
               rr_ptr_d = id_inc(grant_q);
               state_d  = e_idle;
            end
         end
         default: state_d = e_idle;
      endcase
   end

   // Response routing runs independently of the command FSM.
   assign cce_mem_data_resp_o   = mem_data_resp_i;
   assign mem_data_resp_ready_o = ~rd_empty & cce_mem_data_resp_ready_i[rd_head];
   assign cce_mem_data_resp_v_o = (mem_data_resp_v_i & ~rd_empty) ? onehot(rd_head) : '0;
   assign rd_pop                = mem_data_resp_v_i & mem_data_resp_ready_o;

   assign cce_mem_resp_o        = mem_resp_i;
   assign mem_resp_ready_o      = ~wr_empty & cce_mem_resp_ready_i[wr_head];
   assign cce_mem_resp_v_o      = (mem_resp_v_i & ~wr_empty) ? onehot(wr_head) : '0;
   assign wr_pop                = mem_resp_v_i & mem_resp_ready_o;

   assign error_d = error_q | (mem_resp_v_i & wr_empty) | (mem_data_resp_v_i & rd_empty);
   assign error_o = error_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= e_idle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         error_q  <= error_d;
      end
   end

   bp_me_arb_tag_fifo #(.depth_p(outstanding_p), .width_p(id_w)) u_rd_tags (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (rd_push),
      .data_i    (grant_q),
      .pop_i     (rd_pop),
      .data_o    (rd_head),
      .empty_o   (rd_empty),
      .full_o    (rd_full)
   );

   bp_me_arb_tag_fifo #(.depth_p(outstanding_p), .width_p(id_w)) u_wr_tags (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (wr_push),
      .data_i    (grant_q),
      .pop_i     (wr_pop),
      .data_o    (wr_head),
      .empty_o   (wr_empty),
      .full_o    (wr_full)
   );

endmodule

// File: tb/tb_bp_me_cce_mem_arbiter.sv
// Self-checking bench for bp_me_cce_mem_arbiter: arbitration vector table, response
// scoreboard, and hand-written sequences for backpressure, errors and mid-grant reset.
module tb_bp_me_cce_mem_arbiter;

   localparam int N   = 3;
   localparam int CW  = 16;
   localparam int DCW = 24;
   localparam int RW  = 8;
   localparam int DRW = 24;

   logic             clk_i = 1'b0;
   logic             reset_n_i;
   logic [N*CW-1:0]  cce_mem_cmd_i;
   logic [N-1:0]     cce_mem_cmd_v_i, cce_mem_cmd_yumi_o;
   logic [N*DCW-1:0] cce_mem_data_cmd_i;
   logic [N-1:0]     cce_mem_data_cmd_v_i, cce_mem_data_cmd_yumi_o;
   logic [RW-1:0]    cce_mem_resp_o;
   logic [N-1:0]     cce_mem_resp_v_o, cce_mem_resp_ready_i;
   logic [DRW-1:0]   cce_mem_data_resp_o;
   logic [N-1:0]     cce_mem_data_resp_v_o, cce_mem_data_resp_ready_i;
   logic [CW-1:0]    mem_cmd_o;
   logic             mem_cmd_v_o, mem_cmd_yumi_i;
   logic [DCW-1:0]   mem_data_cmd_o;
   logic             mem_data_cmd_v_o, mem_data_cmd_yumi_i;
   logic [RW-1:0]    mem_resp_i;
   logic             mem_resp_v_i, mem_resp_ready_o;
   logic [DRW-1:0]   mem_data_resp_i;
   logic             mem_data_resp_v_i, mem_data_resp_ready_o;
   logic             error_o;

   int checks   = 0;
   int failures = 0;
   int rd_q[$];
   int wr_q[$];

   typedef struct {
      logic [N-1:0] cmd_v;
      logic [N-1:0] dcmd_v;
      int           kind;   // 1 = read granted, 2 = write granted
      int           src;
   } vec_t;
   vec_t vecs[7];

   bp_me_cce_mem_arbiter #(
      .num_req_p(N), .cmd_width_p(CW), .data_cmd_width_p(DCW),
      .resp_width_p(RW), .data_resp_width_p(DRW), .outstanding_p(4)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .cce_mem_cmd_i(cce_mem_cmd_i), .cce_mem_cmd_v_i(cce_mem_cmd_v_i),
      .cce_mem_cmd_yumi_o(cce_mem_cmd_yumi_o),
      .cce_mem_data_cmd_i(cce_mem_data_cmd_i), .cce_mem_data_cmd_v_i(cce_mem_data_cmd_v_i),
      .cce_mem_data_cmd_yumi_o(cce_mem_data_cmd_yumi_o),
      .cce_mem_resp_o(cce_mem_resp_o), .cce_mem_resp_v_o(cce_mem_resp_v_o),
      .cce_mem_resp_ready_i(cce_mem_resp_ready_i),
      .cce_mem_data_resp_o(cce_mem_data_resp_o), .cce_mem_data_resp_v_o(cce_mem_data_resp_v_o),
      .cce_mem_data_resp_ready_i(cce_mem_data_resp_ready_i),
      .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
      .mem_data_cmd_o(mem_data_cmd_o), .mem_data_cmd_v_o(mem_data_cmd_v_o),
      .mem_data_cmd_yumi_i(mem_data_cmd_yumi_i),
      .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
      .mem_data_resp_i(mem_data_resp_i), .mem_data_resp_v_i(mem_data_resp_v_i),
      .mem_data_resp_ready_o(mem_data_resp_ready_o),
      .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      cce_mem_cmd_v_i           = '0;
      cce_mem_data_cmd_v_i      = '0;
      cce_mem_resp_ready_i      = '1;
      cce_mem_data_resp_ready_i = '1;
      mem_cmd_yumi_i            = 1'b0;
      mem_data_cmd_yumi_i       = 1'b0;
      mem_resp_v_i              = 1'b0;
      mem_data_resp_v_i         = 1'b0;
      mem_resp_i                = '0;
      mem_data_resp_i           = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_n_i = 1'b0;
      clear_inputs();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      rd_q.delete();
      wr_q.delete();
   endtask

   // Called at a negedge with the FSM idle and request valids already driven.
   task automatic grant_accept(input int kind, input int src);
      #1;
      chk("idle_no_cmd_v", {mem_cmd_v_o, mem_data_cmd_v_o}, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      if (kind == 1) begin
         chk("cmd_v", mem_cmd_v_o, 1);
         chk("data_cmd_v_quiet", mem_data_cmd_v_o, 0);
         chk("cmd_payload", mem_cmd_o, 64'hC000 | src);
         mem_cmd_yumi_i = 1'b1;
         #1;
         chk("cmd_yumi_route", cce_mem_cmd_yumi_o, 64'(1) << src);
         rd_q.push_back(src);
      end else begin
         chk("data_cmd_v", mem_data_cmd_v_o, 1);
         chk("cmd_v_quiet", mem_cmd_v_o, 0);
         chk("data_cmd_payload", mem_data_cmd_o, 64'hD0000 | src);
         mem_data_cmd_yumi_i = 1'b1;
         #1;
         chk("data_cmd_yumi_route", cce_mem_data_cmd_yumi_o, 64'(1) << src);
         wr_q.push_back(src);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      mem_cmd_yumi_i      = 1'b0;
      mem_data_cmd_yumi_i = 1'b0;
   endtask

   task automatic drain_reads();
      int n = rd_q.size();
      for (int k = 0; k < n; k++) begin
         int exp = rd_q.pop_front();
         @(negedge clk_i);
         mem_data_resp_v_i = 1'b1;
         mem_data_resp_i   = 24'hA00000 | 24'(k);
         if (k == 0) begin
            cce_mem_data_resp_ready_i = ~(N'(1) << exp);
            #1;
            chk("rd_ready_backpressure", mem_data_resp_ready_o, 0);
            chk("rd_v_under_backpressure", cce_mem_data_resp_v_o, 64'(1) << exp);
         end
         cce_mem_data_resp_ready_i = '1;
         #1;
         chk("rd_resp_v_route", cce_mem_data_resp_v_o, 64'(1) << exp);
         chk("rd_resp_ready", mem_data_resp_ready_o, 1);
         chk("rd_resp_payload", cce_mem_data_resp_o, 64'hA00000 | k);
         @(posedge clk_i);
      end
      @(negedge clk_i);
      mem_data_resp_v_i = 1'b0;
   endtask

   task automatic drain_writes();
      int n = wr_q.size();
      for (int k = 0; k < n; k++) begin
         int exp = wr_q.pop_front();
         @(negedge clk_i);
         mem_resp_v_i = 1'b1;
         mem_resp_i   = 8'h50 | 8'(k);
         #1;
         chk("wr_ack_v_route", cce_mem_resp_v_o, 64'(1) << exp);
         chk("wr_ack_ready", mem_resp_ready_o, 1);
         chk("wr_ack_payload", cce_mem_resp_o, 64'h50 | k);
         @(posedge clk_i);
      end
      @(negedge clk_i);
      mem_resp_v_i = 1'b0;
   endtask

   initial begin
      reset_n_i = 1'b0;
      clear_inputs();
      for (int i = 0; i < N; i++) begin
         cce_mem_cmd_i[i*CW +: CW]       = 16'hC000 | 16'(i);
         cce_mem_data_cmd_i[i*DCW +: DCW] = 24'hD0000 | 24'(i);
      end
      #1;
      chk("reset_cmd_v", {mem_cmd_v_o, mem_data_cmd_v_o}, 0);
      chk("reset_yumi", {cce_mem_cmd_yumi_o, cce_mem_data_cmd_yumi_o}, 0);
      chk("reset_resp", {cce_mem_resp_v_o, cce_mem_data_resp_v_o, mem_resp_ready_o, mem_data_resp_ready_o}, 0);
      chk("reset_error", error_o, 0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;

      // Round-robin table from rr_ptr = 0; expected grants derived by hand (N = 3).
      vecs[0] = '{3'b011, 3'b000, 1, 0};
      vecs[1] = '{3'b011, 3'b000, 1, 1};
      vecs[2] = '{3'b001, 3'b100, 2, 2};
      vecs[3] = '{3'b010, 3'b010, 2, 1};
      vecs[4] = '{3'b101, 3'b000, 1, 2};
      vecs[5] = '{3'b110, 3'b001, 2, 0};
      vecs[6] = '{3'b111, 3'b000, 1, 1};
      for (int v = 0; v < 7; v++) begin
         cce_mem_cmd_v_i      = vecs[v].cmd_v;
         cce_mem_data_cmd_v_i = vecs[v].dcmd_v;
         grant_accept(vecs[v].kind, vecs[v].src);
      end
      cce_mem_cmd_v_i      = '0;
      cce_mem_data_cmd_v_i = '0;
      drain_reads();
      drain_writes();
      chk("error_clean_after_table", error_o, 0);

      // CCE0 and CCE1 read together: 0 first, then 1, responses in that order.
      do_reset();
      cce_mem_cmd_v_i = 3'b011;
      grant_accept(1, 0);
      cce_mem_cmd_v_i = 3'b010;
      grant_accept(1, 1);
      cce_mem_cmd_v_i = '0;
      drain_reads();

      // CCE1 write and read together: write first, ack only to CCE1.
      do_reset();
      cce_mem_cmd_v_i      = 3'b010;
      cce_mem_data_cmd_v_i = 3'b010;
      grant_accept(2, 1);
      cce_mem_data_cmd_v_i = '0;
      grant_accept(1, 1);
      cce_mem_cmd_v_i = '0;
      drain_writes();
      drain_reads();

      // Five reads from CCE0 with four tag slots: fifth held until a pop.
      do_reset();
      cce_mem_cmd_v_i = 3'b001;
      for (int k = 0; k < 4; k++) grant_accept(1, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         chk("full_blocks_grant", mem_cmd_v_o, 0);
         chk("full_no_yumi", cce_mem_cmd_yumi_o, 0);
      end
      mem_data_resp_v_i = 1'b1;
      #1;
      chk("full_pop_route", cce_mem_data_resp_v_o, 3'b001);
      chk("full_pop_ready", mem_data_resp_ready_o, 1);
      void'(rd_q.pop_front());
      @(posedge clk_i);
      @(negedge clk_i);
      mem_data_resp_v_i = 1'b0;
      chk("pop_same_cycle_still_blocked", mem_cmd_v_o, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("fifth_granted", mem_cmd_v_o, 1);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("grant_held_without_yumi", mem_cmd_v_o, 1);
      mem_cmd_yumi_i = 1'b1;
      rd_q.push_back(0);
      @(posedge clk_i);
      @(negedge clk_i);
      mem_cmd_yumi_i  = 1'b0;
      cce_mem_cmd_v_i = '0;
      drain_reads();

      // Write ack with nothing outstanding.
      do_reset();
      mem_resp_v_i = 1'b1;
      #1;
      chk("empty_ack_ready", mem_resp_ready_o, 0);
      chk("empty_ack_v", cce_mem_resp_v_o, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      mem_resp_v_i = 1'b0;
      chk("error_set", error_o, 1);
      repeat (3) @(negedge clk_i);
      chk("error_sticky", error_o, 1);

      // Reset pulse while in e_cmd with two tags outstanding.
      do_reset();
      cce_mem_cmd_v_i = 3'b001;
      grant_accept(1, 0);
      grant_accept(1, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("pre_reset_in_cmd", mem_cmd_v_o, 1);
      mem_cmd_yumi_i = 1'b1;
      reset_n_i      = 1'b0;
      #1;
      chk("reset_mid_cmd_v", mem_cmd_v_o, 0);
      chk("reset_mid_yumi", cce_mem_cmd_yumi_o, 0);
      chk("reset_mid_rd_ready", mem_data_resp_ready_o, 0);
      clear_inputs();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      rd_q.delete();
      mem_data_resp_v_i = 1'b1;
      #1;
      chk("post_reset_no_route", cce_mem_data_resp_v_o, 0);
      chk("post_reset_fifo_empty", mem_data_resp_ready_o, 0);
      @(negedge clk_i);
      mem_data_resp_v_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
